// File: rtl/song_sequencer_if.sv
// Control, ROM and output bundle of the song sequencer.
// The slave modport is the sequencer; the master is the host that also serves the ROM.
interface song_sequencer_if;
   logic       start;
   logic [1:0] song_select;
   logic [1:0] speed_select;
   logic [7:0] rom_addr;
   logic [9:0] rom_data;
   logic [3:0] note_out;
   logic [1:0] octave_out;
   logic [6:0] led_out;
   logic [1:0] song_num;
   logic       busy;
   logic       done;

   modport master (
      output start, song_select, speed_select, rom_data,
      input  rom_addr, note_out, octave_out, led_out, song_num, busy, done
   );

   modport slave (
      input  start, song_select, speed_select, rom_data,
      output rom_addr, note_out, octave_out, led_out, song_num, busy, done
   );
endinterface

// File: rtl/song_sequencer.sv
// Plays note/duration words from an external synchronous ROM with a tempo prescaler,
// one-tick gaps between notes, pause/resume and song selection.
module song_sequencer #(
   parameter int TICK_DIV  = 12_500_000,
   parameter int NUM_SONGS = 3
) (
   input logic               clk,
   input logic               reset,
   song_sequencer_if.slave   bus
);

   localparam int PW = $clog2(TICK_DIV * 2 + 1);
   localparam logic [PW-1:0] P_NORM = PW'(TICK_DIV);
   localparam logic [PW-1:0] P_FAST = PW'(TICK_DIV / 2);
   localparam logic [PW-1:0] P_SLOW = PW'(TICK_DIV * 2);
   localparam logic [1:0]    LAST_SONG = 2'(NUM_SONGS - 1);

   typedef enum logic [2:0] {IDLE, FETCH, LOAD, PLAY, GAP, PAUSE, DONE} state_t;

   state_t        state, state_nxt;
   logic [1:0]    song_idx;
   logic [5:0]    step;
   logic [3:0]    note_r;
   logic [1:0]    oct_r;
   logic [3:0]    dur_cnt;
   logic [PW-1:0] presc;
   logic [PW-1:0] period;
   logic [PW-1:0] period_sel;
   logic          tick;

   wire [3:0] rom_note = bus.rom_data[9:6];
   wire [1:0] rom_oct  = bus.rom_data[5:4];
   wire [3:0] rom_dur  = bus.rom_data[3:0];

   assign tick = (presc == period - PW'(1));

   always_comb begin
      period_sel = P_NORM;
      case (bus.speed_select)
         2'b01:   period_sel = P_FAST;
         2'b10:   period_sel = P_SLOW;
         default: period_sel = P_NORM;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // NOTE: default assigned first so no path through the case can infer a latch.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = FETCH;
         FETCH:   state_nxt = LOAD;
         LOAD:    state_nxt = (rom_note == 4'd15) ? DONE : PLAY;
         PLAY: begin
            // Expiry wins over a pause request landing on the same edge.
            if (tick && dur_cnt == 4'd1) state_nxt = GAP;
            else if (bus.start)          state_nxt = PAUSE;
         end
         PAUSE:   if (bus.start) state_nxt = PLAY;
         GAP:     if (tick) state_nxt = (step == 6'd63) ? DONE : FETCH;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         song_idx <= '0;
         step     <= '0;
         note_r   <= '0;
         oct_r    <= '0;
         dur_cnt  <= '0;
         presc    <= '0;
         period   <= P_NORM;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  step <= '0;
               end else if (bus.song_select == 2'b01) begin
                  song_idx <= (song_idx == LAST_SONG) ? 2'd0 : song_idx + 2'd1;
               end else if (bus.song_select == 2'b10) begin
                  song_idx <= (song_idx == 2'd0) ? LAST_SONG : song_idx - 2'd1;
               end
            end
            LOAD: begin
               note_r  <= rom_note;
               oct_r   <= rom_oct;
               dur_cnt <= (rom_dur == 4'd0) ? 4'd1 : rom_dur;
               presc   <= '0;
               period  <= period_sel;
            end
            PLAY, GAP: begin
               // The pausing edge is still a PLAY cycle, so the prescaler advances on it.
               presc <= tick ? '0 : presc + PW'(1);
               if (tick) period <= period_sel;
               if (state == PLAY && tick) dur_cnt <= dur_cnt - 4'd1;
               if (state == GAP && tick && step != 6'd63) step <= step + 6'd1;
            end
            default: ;
         endcase
      end
   end

   // Outputs decode from state so an asynchronous reset silences them without a clock.
   always_comb begin
      bus.note_out = 4'd0;
      if (state == PLAY && note_r <= 4'd7) bus.note_out = note_r;
      bus.led_out = 7'd0;
      if (bus.note_out != 4'd0) bus.led_out = 7'd1 << (bus.note_out - 4'd1);
   end

   assign bus.octave_out = oct_r;
   assign bus.rom_addr   = {song_idx, step};
   assign bus.song_num   = song_idx;
   assign bus.busy       = (state != IDLE);
   assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench: a bench-side ROM plus a per-cycle expected trace built from
// the song rules (fetch/load, dur*period of note, one period of gap, done pulse).
module tb_song_sequencer;
   localparam int TD = 4;

   typedef struct {
      logic [3:0] note;
      logic [6:0] led;
      logic       busy;
      logic       done;
      logic [1:0] oct;
      logic       chk_oct;
   } exp_t;

   logic clk;
   logic reset;
   int   tests;
   int   fails;
   logic [9:0] rom [256];
   exp_t q [$];

   song_sequencer_if bus ();

   song_sequencer #(.TICK_DIV(TD), .NUM_SONGS(3)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] word(input int n, input int o, input int d);
      return {4'(n), 2'(o), 4'(d)};
   endfunction

   function automatic exp_t mk(input logic [3:0] n, input logic d, input logic [1:0] o,
                               input logic c);
      exp_t e;
      e.note    = n;
      e.led     = (n == 4'd0) ? 7'd0 : (7'd1 << (n - 4'd1));
      e.busy    = 1'b1;
      e.done    = d;
      e.oct     = o;
      e.chk_oct = c;
      return e;
   endfunction

   // Expected per-cycle trace starting with the first FETCH cycle.
   task automatic build(input int song, input logic [1:0] spd);
      int         p;
      int         len;
      bit         ended;
      logic [9:0] w;
      logic [3:0] nv;
      p = (spd == 2'b01) ? TD / 2 : (spd == 2'b10) ? TD * 2 : TD;
      ended = 1'b0;
      q.delete();
      for (int s = 0; s < 64 && !ended; s++) begin
         w = rom[song * 64 + s];
         q.push_back(mk(4'd0, 1'b0, 2'd0, 1'b0));
         q.push_back(mk(4'd0, 1'b0, 2'd0, 1'b0));
         if (w[9:6] == 4'd15) begin
            ended = 1'b1;
         end else begin
            nv  = (w[9:6] <= 4'd7) ? w[9:6] : 4'd0;
            len = ((w[3:0] == 4'd0) ? 1 : int'(w[3:0])) * p;
            for (int k = 0; k < len; k++) q.push_back(mk(nv, 1'b0, w[5:4], 1'b1));
            for (int k = 0; k < p; k++) q.push_back(mk(4'd0, 1'b0, 2'd0, 1'b0));
         end
      end
      q.push_back(mk(4'd0, 1'b1, 2'd0, 1'b0));
   endtask

   // Plays one song; pause_at >= 0 presses start in that cycle and again 10 cycles later.
   task automatic play(input string tag, input int song, input logic [1:0] spd,
                       input int pause_at);
      build(song, spd);
      if (pause_at >= 0)
         for (int k = 0; k < 10; k++) q.insert(pause_at + 1, mk(4'd0, 1'b0, 2'd0, 1'b0));
      bus.speed_select = spd;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      for (int i = 0; i < q.size(); i++) begin
         bus.start = (pause_at >= 0) && (i == pause_at || i == pause_at + 10);
         @(negedge clk);
         check({tag, "_note"}, 32'(bus.note_out), 32'(q[i].note));
         check({tag, "_led"},  32'(bus.led_out),  32'(q[i].led));
         check({tag, "_busy"}, 32'(bus.busy),     32'(q[i].busy));
         check({tag, "_done"}, 32'(bus.done),     32'(q[i].done));
         check({tag, "_bank"}, 32'(bus.rom_addr[7:6]), 32'(song));
         if (q[i].chk_oct) check({tag, "_oct"}, 32'(bus.octave_out), 32'(q[i].oct));
         @(posedge clk); #1;
      end
      bus.start = 1'b0;
      @(negedge clk);
      check({tag, "_end_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_end_done"}, 32'(bus.done), 32'd0);
   endtask

   task automatic pulse_sel(input logic [1:0] sel);
      @(posedge clk); #1 bus.song_select = sel;
      @(posedge clk); #1 bus.song_select = 2'b00;
      @(negedge clk);
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (bus.busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_idle"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      int         len;
      logic [1:0] spd;
      tests = 0;
      fails = 0;
      reset = 1'b0;
      bus.start = 1'b0;
      bus.song_select = 2'b00;
      bus.speed_select = 2'b00;
      for (int i = 0; i < 256; i++) rom[i] = word(15, 0, 0);
      rom[0] = word(1, 1, 2);
      rom[1] = word(3, 2, 1);
      rom[2] = word(15, 0, 0);
      for (int i = 0; i < 64; i++) rom[64 + i] = word(2, 1, 1);
      rom[128] = word(0, 2, 3);
      rom[129] = word(9, 1, 2);
      rom[130] = word(15, 0, 0);

      repeat (3) @(negedge clk);
      check("rst_addr", 32'(bus.rom_addr), 32'd0);
      check("rst_note", 32'(bus.note_out), 32'd0);
      check("rst_oct",  32'(bus.octave_out), 32'd0);
      check("rst_led",  32'(bus.led_out), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_song", 32'(bus.song_num), 32'd0);
      reset = 1'b1;

      play("s0_norm", 0, 2'b00, -1);
      play("s0_fast", 0, 2'b01, -1);
      play("s0_slow", 0, 2'b10, -1);
      play("s0_pause", 0, 2'b00, 4);

      pulse_sel(2'b10);
      check("prev_0_to_2", 32'(bus.song_num), 32'd2);
      play("s2_silent", 2, 2'b00, -1);

      for (int r = 0; r < 6; r++) begin
         len = $urandom_range(1, 5);
         for (int j = 0; j < len; j++)
            rom[128 + j] = word($urandom_range(0, 14), $urandom_range(0, 3), $urandom_range(0, 3));
         rom[128 + len] = word(15, 0, 0);
         spd = 2'($urandom_range(0, 3));
         play("s2_rand", 2, spd, -1);
      end

      pulse_sel(2'b01);
      check("next_2_to_0", 32'(bus.song_num), 32'd0);
      pulse_sel(2'b11);
      check("sel_11_ignored", 32'(bus.song_num), 32'd0);

      bus.speed_select = 2'b00;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (4) @(posedge clk);
      pulse_sel(2'b01);
      pulse_sel(2'b10);
      check("sel_busy_song", 32'(bus.song_num), 32'd0);
      check("sel_busy_busy", 32'(bus.busy), 32'd1);
      wait_idle("sel_busy");

      @(posedge clk); #1 begin bus.start = 1'b1; bus.song_select = 2'b01; end
      @(posedge clk); #1 begin bus.start = 1'b0; bus.song_select = 2'b00; end
      @(negedge clk);
      check("start_prio_song", 32'(bus.song_num), 32'd0);
      check("start_prio_busy", 32'(bus.busy), 32'd1);
      wait_idle("start_prio");

      pulse_sel(2'b01);
      check("next_0_to_1", 32'(bus.song_num), 32'd1);
      play("s1_64steps", 1, 2'b01, -1);

      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("pre_rst_note", 32'(bus.note_out), 32'd2);
      #2 reset = 1'b0;
      #1;
      check("async_note", 32'(bus.note_out), 32'd0);
      check("async_led",  32'(bus.led_out), 32'd0);
      check("async_oct",  32'(bus.octave_out), 32'd0);
      check("async_busy", 32'(bus.busy), 32'd0);
      check("async_done", 32'(bus.done), 32'd0);
      check("async_addr", 32'(bus.rom_addr), 32'd0);
      check("async_song", 32'(bus.song_num), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      @(negedge clk);
      check("restart_addr", 32'(bus.rom_addr), 32'h00);
      check("restart_busy", 32'(bus.busy), 32'd1);
      wait_idle("restart");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
